alu_rr_arbiter: RTL

//  Shares one ALU instance (opcodes 0000-1001) between NUM_REQ requesters.

---
 rtl/alu_rr_arbiter_if.sv | 32 +++
 rtl/alu_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between the requesting engines and the shared-ALU arbiter.
// Requester i uses lane i of every packed request field.
interface alu_rr_arbiter_if #(
    parameter int IN_WIDTH = 8,
    parameter int NUM_REQ  = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*IN_WIDTH-1:0] req_a;
    logic [NUM_REQ*IN_WIDTH-1:0] req_b;
    logic [NUM_REQ*4-1:0]        req_opcode;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [ID_W-1:0]             rsp_id;
    logic [2*IN_WIDTH-1:0]       rsp_result;
    logic [2:0]                  rsp_flags;
    logic                        rsp_err;
    logic                        busy;
    logic [15:0]                 op_count;

    modport master (
        output req_valid, req_a, req_b, req_opcode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy, op_count
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned ALU between NUM_REQ requesters.
// One op in flight: IDLE grants, EXEC enables the ALU, RESP holds the result until accepted.
module alu_rr_arbiter #(
    parameter int IN_WIDTH = 8,
    parameter int NUM_REQ  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_rr_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int RW   = 2 * IN_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [ID_W-1:0]     w_grant;
    logic                w_grant_vld;
    logic [NUM_REQ-1:0]  w_ready;
    logic [IN_WIDTH-1:0] r_a;
    logic [IN_WIDTH-1:0] r_b;
    logic [3:0]          r_op;
    logic [ID_W-1:0]     r_id;
    logic                w_alu_en;
    logic [RW-1:0]       w_alu_result;
    logic [2:0]          w_alu_flags;
    logic                w_alu_err;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [RW-1:0]       r_rsp_result;
    logic [2:0]          r_rsp_flags;
    logic                r_rsp_err;
    logic [15:0]         r_op_count;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    // Circular search for the first valid requester at or after the pointer.
    always_comb begin
        w_grant     = {ID_W{1'b0}};
        w_grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_grant     = (!w_grant_vld && bus.req_valid[rr_index(r_ptr, k)]) ? rr_index(r_ptr, k) : w_grant;
            w_grant_vld = w_grant_vld | bus.req_valid[rr_index(r_ptr, k)];
        end
    end

    // Next-state, grant strobe and pointer advance.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ready     = {NUM_REQ{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_ready[w_grant] = 1'b1;
                    w_ptr_nxt        = rr_index(w_grant, 1);
                    w_state_nxt      = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_alu_en = (r_state == ST_EXEC);

    // Shared ALU; outputs are forced to zero whenever it is not enabled.
    always_comb begin
        w_alu_result = {RW{1'b0}};
        w_alu_flags  = 3'b000;
        w_alu_err    = 1'b0;
        if (w_alu_en) begin
            case (r_op)
                4'd0: w_alu_result = RW'(r_a) + RW'(r_b);
                4'd1: w_alu_result = RW'(r_a) - RW'(r_b);
                4'd2: w_alu_result = RW'(r_a & r_b);
                4'd3: w_alu_result = RW'(r_a | r_b);
                4'd4: w_alu_result = RW'(r_a ^ r_b);
                4'd5: w_alu_result = RW'(r_a) << r_b;
                4'd6: w_alu_result = RW'(r_a) >> r_b;
                4'd7: w_alu_result = RW'(r_a) * RW'(r_b);
                4'd8: begin
                    if (r_b == {IN_WIDTH{1'b0}}) begin
                        w_alu_err = 1'b1;
                    end else begin
                        w_alu_result = RW'(r_a / r_b);
                    end
                end
                4'd9: w_alu_flags = {r_a > r_b, r_a == r_b, r_a < r_b};
                default: w_alu_err = 1'b1;
            endcase
        end else begin
            w_alu_err = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, round-robin pointer, response and op counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= {ID_W{1'b0}};
            r_a          <= {IN_WIDTH{1'b0}};
            r_b          <= {IN_WIDTH{1'b0}};
            r_op         <= 4'd0;
            r_id         <= {ID_W{1'b0}};
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= {ID_W{1'b0}};
            r_rsp_result <= {RW{1'b0}};
            r_rsp_flags  <= 3'b000;
            r_rsp_err    <= 1'b0;
            r_op_count   <= 16'd0;
        end else begin
            r_ptr <= w_ptr_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_a  <= bus.req_a[w_grant*IN_WIDTH +: IN_WIDTH];
                        r_b  <= bus.req_b[w_grant*IN_WIDTH +: IN_WIDTH];
                        r_op <= bus.req_opcode[w_grant*4 +: 4];
                        r_id <= w_grant;
                    end else begin
                        r_id <= r_id;
                    end
                end
                ST_EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= w_alu_result;
                    r_rsp_flags  <= w_alu_flags;
                    r_rsp_err    <= w_alu_err;
                    r_op_count   <= r_op_count + 16'd1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= r_rsp_valid;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    // Grant strobe is combinational, so it is also masked while reset is asserted.
    assign bus.req_ready  = rst_n ? w_ready : {NUM_REQ{1'b0}};
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.op_count   = r_op_count;
endmodule
